inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-005 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: imem_addr  output  ADDR_W  word address driven to the instruction memory read port.
REQ-008 SHALL have port: imem_data  input  DATA_W  combinational read data returned for imem_addr in the same cycle.
REQ-009 SHALL have port: id_ready  input  1  decode stage accepts the current ir_out this cycle.
REQ-010 SHALL have port: branch_taken  input  1  single-cycle redirect request from execute.
REQ-011 SHALL have port: branch_target  input  ADDR_W  redirect address, sampled when branch_taken=1.
REQ-012 SHALL have port: ir_out  output  DATA_W  registered instruction presented to decode.
REQ-013 SHALL have port: pc_out  output  ADDR_W  address from which ir_out was fetched.
REQ-014 SHALL have port: ir_valid  output  1  ir_out/pc_out hold a live instruction.
REQ-015 SHALL have port: halted  output  1  fetch stopped by HALT_WORD.
REQ-016 SHALL have port: fetch_count  output  32  number of instructions handed to decode (ir_valid && id_ready cycles).

Function
REQ-017 SHALL implement states BOOT, FETCH, HALT; halted=1 exactly when state=HALT.
REQ-018 SHALL drive imem_addr combinationally from the internal pc register, with no added latency.
REQ-019 SHALL leave BOOT unconditionally one cycle after reset deassertion to FETCH (memory initialisation settle cycle), with ir_valid=0 throughout BOOT.
REQ-020 SHALL, in FETCH when the IR slot is free (ir_valid=0 or id_ready=1) and branch_taken=0: load ir_out<=imem_data, pc_out<=pc, ir_valid<=1, pc<=pc+1 (one-cycle fetch latency).
REQ-021 SHALL, when ir_valid=1 and id_ready=0 and branch_taken=0, hold pc, ir_out, pc_out and ir_valid unchanged (stall).
REQ-022 SHALL give branch_taken priority over stall, halt and fetch in every state except BOOT: pc<=branch_target, ir_valid<=0 (flush of in-flight instruction), state<=FETCH.
REQ-023 SHALL ignore branch_taken during BOOT.
REQ-024 SHALL, when HALT_WORD would be loaded per REQ-020, instead set ir_valid<=0, keep pc at the halt address, and enter HALT; HALT_WORD is never presented on ir_out.
REQ-025 SHALL, in HALT, hold pc and keep ir_valid=0 until branch_taken or reset.
REQ-026 SHALL wrap pc modulo 2^ADDR_W (16'hFFFF + 1 = 16'h0000) with no error indication.
REQ-027 SHALL increment fetch_count by 1 on each cycle with ir_valid=1 and id_ready=1, including a cycle where branch_taken also flushes; fetch_count wraps at 2^32.

Reset
REQ-028 SHALL, on reset assertion at any time (mid-stall, mid-halt included), immediately set pc=RESET_PC, ir_out=0, pc_out=0, ir_valid=0, fetch_count=0, state=BOOT, without waiting for clk.
REQ-029 SHALL hold all reset values for as long as reset is high.

Structure
REQ-030 SHALL place the state encoding (BOOT, FETCH, HALT), HALT_WORD default and ADDR_W/DATA_W defaults in the shared cpu package.
REQ-031 SHALL be a single flat module; no sub-module is required.

Verification
REQ-032 SHALL cover: reset release with memory words 0..3 = A,B,C,D and id_ready=1 -> ir_valid=0 for BOOT cycle, then ir_out=A/pc_out=0, B/1, C/2, D/3 on consecutive cycles; fetch_count=4.
REQ-033 SHALL cover: id_ready=0 for 3 cycles while ir_out=B -> ir_out=B, pc_out=1, imem_addr=2 held for 3 cycles, then C follows.
REQ-034 SHALL cover: branch_taken=1, branch_target=16'h0006 while stalled on B -> next cycle ir_valid=0, imem_addr=6; following cycle ir_out=mem[6], pc_out=6.
REQ-035 SHALL cover: mem[4]=32'hFFFF_FFFF -> after D accepted, halted=1, ir_valid=0, imem_addr=4 stays; branch_taken to 0 -> halted=0, refetch from address 0.
REQ-036 SHALL cover: pc=16'hFFFF fetch -> next imem_addr=16'h0000, pc_out=16'hFFFF.
REQ-037 SHALL cover: reset asserted between clock edges while halted -> halted=0, ir_valid=0, imem_addr=RESET_PC, fetch_count=0 before the next posedge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared cpu package: fetch state encoding and width/halt defaults
package inst_fetch_pkg;

  localparam int          ADDR_W_DEF    = 16;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-slot instruction fetch stage with stall, redirect and halt
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              id_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  assign slot_free = !ir_valid || id_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      ir_out      <= '0;
      pc_out      <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A handoff counts even when a redirect flushes the slot in the same cycle.
      if (ir_valid && id_ready)
        fetch_count <= fetch_count + 32'd1;

      if (state == ST_BOOT) begin
        state <= ST_FETCH;
      end else if (branch_taken) begin
        pc       <= branch_target;
        ir_valid <= 1'b0;
        state    <= ST_FETCH;
      end else if (state == ST_FETCH && slot_free) begin
        if (imem_data == HALT_WORD) begin
          ir_valid <= 1'b0;
          state    <= ST_HALT;
        end else begin
          ir_out   <= imem_data;
          pc_out   <= pc;
          ir_valid <= 1'b1;
          pc       <= pc + ADDR_W'(1);
        end
      end
    end
  end

endmodule
